key_event_ctrl: RTL

Downstream consumer of the push-button debouncer. Takes the four debounced key levels and the 100 Hz clock enable, runs one tick-based state machine per key, and turns level changes into single-cycle event pulses: press, release, long-press and auto-repeat. It also serializes those events into one valid/ready event stream for the user-interface controller.

---
 rtl/key_event_ctrl_pkg.sv | 23 ++
 rtl/key_event_ctrl_fsm.sv | 136 +++++++++++++
 rtl/key_event_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/key_event_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// key_event_ctrl_pkg
// Shared constants for the key event controller: event type codes presented
// on the event stream, per-key FSM state encoding, tick counter width and the
// number of keys.
// -----------------------------------------------------------------------------
package key_event_ctrl_pkg;

    localparam int CNT_W    = 8;
    localparam int NUM_KEYS = 4;

    // Event type codes carried on ev_type
    localparam logic [1:0] EV_PRESS   = 2'b00;
    localparam logic [1:0] EV_RELEASE = 2'b01;
    localparam logic [1:0] EV_LONG    = 2'b10;
    localparam logic [1:0] EV_REPEAT  = 2'b11;

    // Per-key FSM states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HELD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

endpackage

// File: rtl/key_event_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// key_event_fsm
// Tick-based event generator for one debounced key. Evaluates the key level
// only on clken ticks and produces press / release / long-press / repeat.
//
// Ports:
//   i_clock, i_reset   clock, asynchronous active-high reset
//   i_clken            100 Hz tick; all sampling and counting happen on it
//   i_key              debounced key level, 1 = pressed
//   o_press, o_release, o_long, o_repeat
//                      registered one-clock pulses, high the cycle after the tick
//   o_ev_stb, o_ev_type
//                      combinational event strobe/type during the tick cycle,
//                      so the pending slot fills at the same edge as the pulse
//   o_state            current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module key_event_fsm
    import key_event_ctrl_pkg::*;
#(
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_clken,
    input  logic       i_key,
    output logic       o_press,
    output logic       o_release,
    output logic       o_long,
    output logic       o_repeat,
    output logic       o_ev_stb,
    output logic [1:0] o_ev_type,
    output logic [1:0] o_state
);

    localparam logic [CNT_W-1:0] LONG_CMP   = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] REPEAT_CMP = CNT_W'(REPEAT_TICKS);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_prev;
    logic             r_press, r_release, r_long, r_repeat;
    logic             w_ev_stb;
    logic [1:0]       w_ev_type;

    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_ev_stb   = 1'b0;
        w_ev_type  = EV_PRESS;
        if (i_clken) begin
            case (r_state)
                ST_IDLE: begin
                    // Rising level on a tick; a key held through reset sees
                    // r_prev = 0 and so still yields a press.
                    if (i_key && !r_prev) begin
                        w_ev_stb   = 1'b1;
                        w_ev_type  = EV_PRESS;
                        w_cnt_nx   = '0;
                        w_state_nx = ST_HELD;
                    end
                end
                ST_HELD: begin
                    // Release outranks a threshold hit on the same tick
                    if (!i_key) begin
                        w_ev_stb   = 1'b1;
                        w_ev_type  = EV_RELEASE;
                        w_cnt_nx   = '0;
                        w_state_nx = ST_IDLE;
                    end else if (w_cnt_inc == LONG_CMP) begin
                        w_ev_stb   = 1'b1;
                        w_ev_type  = EV_LONG;
                        w_cnt_nx   = '0;
                        w_state_nx = ST_REPEAT;
                    end else begin
                        w_cnt_nx   = w_cnt_inc;
                    end
                end
                ST_REPEAT: begin
                    if (!i_key) begin
                        w_ev_stb   = 1'b1;
                        w_ev_type  = EV_RELEASE;
                        w_cnt_nx   = '0;
                        w_state_nx = ST_IDLE;
                    end else if (w_cnt_inc == REPEAT_CMP) begin
                        w_ev_stb   = 1'b1;
                        w_ev_type  = EV_REPEAT;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx   = w_cnt_inc;
                    end
                end
                default: begin
                    w_cnt_nx   = '0;
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_prev    <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            if (i_clken) begin
                r_prev <= i_key;
            end
            r_press   <= w_ev_stb && (w_ev_type == EV_PRESS);
            r_release <= w_ev_stb && (w_ev_type == EV_RELEASE);
            r_long    <= w_ev_stb && (w_ev_type == EV_LONG);
            r_repeat  <= w_ev_stb && (w_ev_type == EV_REPEAT);
        end
    end

    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;
    assign o_repeat  = r_repeat;
    assign o_ev_stb  = w_ev_stb;
    assign o_ev_type = w_ev_type;
    assign o_state   = r_state;

endmodule

// File: rtl/key_event_ctrl.sv
// -----------------------------------------------------------------------------
// key_event_ctrl
// Turns four debounced key levels into per-key event pulses and serializes
// the events into one valid/ready stream.
//
// Ports:
//   i_clock, i_reset         clock, asynchronous active-high reset
//   i_clken100hz             100 Hz tick from the debouncer
//   i_key0in..i_key3in       debounced key levels, 1 = pressed
//   o_press/o_release/o_longpress/o_repeat [3:0]
//                            one-clock event pulses, one bit per key
//   o_ev_valid, o_ev_key, o_ev_type, i_ev_ready
//                            event stream
//   o_ev_ovf                 sticky: an undelivered event was overwritten
//   o_dbg_state [7:0]        per-key FSM state, key k in bits [2k+1:2k]
//
// Handshake: an event transfers on a cycle where o_ev_valid && i_ev_ready.
// While o_ev_valid is high and i_ev_ready is low, o_ev_key/o_ev_type hold
// stable; each event is presented until accepted and delivered once.
// -----------------------------------------------------------------------------
module key_event_ctrl
    import key_event_ctrl_pkg::*;
#(
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_clken100hz,
    input  logic       i_key0in,
    input  logic       i_key1in,
    input  logic       i_key2in,
    input  logic       i_key3in,
    output logic [3:0] o_press,
    output logic [3:0] o_release,
    output logic [3:0] o_longpress,
    output logic [3:0] o_repeat,
    output logic       o_ev_valid,
    output logic [1:0] o_ev_key,
    output logic [1:0] o_ev_type,
    input  logic       i_ev_ready,
    output logic       o_ev_ovf,
    output logic [7:0] o_dbg_state
);

    logic [NUM_KEYS-1:0] w_keys;
    logic [NUM_KEYS-1:0] w_ev_stb;
    logic [1:0]          w_ev_type [NUM_KEYS];

    logic [NUM_KEYS-1:0] r_pend_vld;
    logic [1:0]          r_pend_type [NUM_KEYS];

    logic                r_ev_valid;
    logic [1:0]          r_ev_key;
    logic [1:0]          r_ev_type;
    logic                r_ev_ovf;

    logic                w_load;
    logic                w_sel_vld;
    logic [1:0]          w_sel_key;
    logic [NUM_KEYS-1:0] w_clr;

    assign w_keys = {i_key3in, i_key2in, i_key1in, i_key0in};

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_event_fsm #(
            .LONG_TICKS   (LONG_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_fsm (
            .i_clock   (i_clock),
            .i_reset   (i_reset),
            .i_clken   (i_clken100hz),
            .i_key     (w_keys[g]),
            .o_press   (o_press[g]),
            .o_release (o_release[g]),
            .o_long    (o_longpress[g]),
            .o_repeat  (o_repeat[g]),
            .o_ev_stb  (w_ev_stb[g]),
            .o_ev_type (w_ev_type[g]),
            .o_state   (o_dbg_state[2*g +: 2])
        );
    end

    // Output register refills when empty or when its event is being taken
    assign w_load = !r_ev_valid || i_ev_ready;

    // Fixed priority: scanning downwards leaves the lowest full slot selected
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_key = 2'd0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (r_pend_vld[k]) begin
                w_sel_vld = 1'b1;
                w_sel_key = 2'(k);
            end
        end
    end

    always_comb begin
        w_clr = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            w_clr[k] = w_load && w_sel_vld && (w_sel_key == 2'(k));
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_pend_vld <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                r_pend_type[k] <= EV_PRESS;
            end
            r_ev_valid <= 1'b0;
            r_ev_key   <= 2'd0;
            r_ev_type  <= EV_PRESS;
            r_ev_ovf   <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (w_ev_stb[k]) begin
                    // A new event beats a same-cycle clear; only a slot that
                    // stays occupied counts as overwritten.
                    r_pend_vld[k]  <= 1'b1;
                    r_pend_type[k] <= w_ev_type[k];
                    if (r_pend_vld[k] && !w_clr[k]) begin
                        r_ev_ovf <= 1'b1;
                    end
                end else if (w_clr[k]) begin
                    r_pend_vld[k] <= 1'b0;
                end
            end
            if (w_load) begin
                r_ev_valid <= w_sel_vld;
                if (w_sel_vld) begin
                    r_ev_key  <= w_sel_key;
                    r_ev_type <= r_pend_type[w_sel_key];
                end
            end
        end
    end

    assign o_ev_valid = r_ev_valid;
    assign o_ev_key   = r_ev_key;
    assign o_ev_type  = r_ev_type;
    assign o_ev_ovf   = r_ev_ovf;

endmodule
